// File: rtl/do_pkg.sv
// Shared definitions for digital-output channels: FSM encodings, register offsets, LED codes.
package do_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOn    = 2'd1,
    StPulse = 2'd2,
    StFault = 2'd3
  } do_state_e;

  localparam logic [5:0] OffCtrl   = 6'h00;
  localparam logic [5:0] OffCmd    = 6'h01;
  localparam logic [5:0] OffPwLo   = 6'h02;
  localparam logic [5:0] OffPwHi   = 6'h03;
  localparam logic [5:0] OffStatus = 6'h04;

  localparam logic [1:0] LedOff   = 2'b00;
  localparam logic [1:0] LedEnLow = 2'b01;
  localparam logic [1:0] LedHigh  = 2'b10;
  localparam logic [1:0] LedFault = 2'b11;

  localparam int unsigned WinSize = 64;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/do_ch.sv
// Single digital-output channel: level/pulse drive, feedback supervision with latched fault,
// LED code, and a byte-wide parameter/readback window at CH_ADD.
module do_ch
  import do_pkg::*;
#(
  parameter int unsigned CH_ADD = 0,
  parameter int unsigned FB_CHK = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] im_paraddr,
  input  logic        i_parwren,
  input  logic [7:0]  im_pardata,
  input  logic [11:0] im_rdaddr,
  input  logic        i_rdren,
  output logic [7:0]  om_rddata,
  input  logic        i_fb,
  output logic        o_dout,
  output logic        o_fault,
  output logic [1:0]  led_ctrl
);

  localparam int unsigned    MmW      = $clog2(FB_CHK + 1);
  localparam logic [MmW-1:0] MmMax    = MmW'(FB_CHK);
  localparam logic [11:0]    BaseAddr = 12'(CH_ADD);

  logic fb_s;

  sync2 u_fb_sync (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .d_i    (i_fb),
    .q_o    (fb_s)
  );

  logic [11:0] wr_diff, rd_diff;
  logic        wr_hit, rd_hit;
  logic [5:0]  wr_off, rd_off;

  always_comb begin
    wr_diff = im_paraddr - BaseAddr;
    rd_diff = im_rdaddr - BaseAddr;
    wr_hit  = i_parwren && (im_paraddr >= BaseAddr) && (wr_diff < 12'(WinSize));
    rd_hit  = i_rdren && (im_rdaddr >= BaseAddr) && (rd_diff < 12'(WinSize));
    wr_off  = wr_diff[5:0];
    rd_off  = rd_diff[5:0];
  end

  // Configuration registers; trig_q and fclr_q are one-cycle event strobes.
  logic        en_q, mode_q, cmd_q, trig_q, fclr_q;
  logic [15:0] pw_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q   <= 1'b0;
      mode_q <= 1'b0;
      cmd_q  <= 1'b0;
      trig_q <= 1'b0;
      fclr_q <= 1'b0;
      pw_q   <= 16'd1;
    end else begin
      trig_q <= 1'b0;
      fclr_q <= 1'b0;
      if (wr_hit) begin
        case (wr_off)
          OffCtrl: begin
            en_q   <= im_pardata[0];
            mode_q <= im_pardata[1];
            fclr_q <= im_pardata[2];
          end
          OffCmd: begin
            cmd_q  <= im_pardata[0];
            trig_q <= im_pardata[0];
          end
          OffPwLo: pw_q[7:0]  <= im_pardata;
          OffPwHi: pw_q[15:8] <= im_pardata;
          default: ;
        endcase
      end
    end
  end

  do_state_e      state_q, state_d;
  logic [15:0]    pcnt_q, pcnt_d;
  logic [MmW-1:0] mm_q, mm_d;
  logic           dout_q, dout_d;
  logic           fault_q, fault_d;
  logic [1:0]     led_q, led_d;
  logic [7:0]     rd_q, rd_d;
  logic           chk_en;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    mm_d    = mm_q;
    dout_d  = (state_q == StOn) || (state_q == StPulse);
    fault_d = (state_q == StFault);
    chk_en  = en_q && (state_q != StFault);

    unique case (state_q)
      StIdle: begin
        if (en_q && !mode_q && cmd_q) begin
          state_d = StOn;
        end else if (en_q && mode_q && trig_q) begin
          state_d = StPulse;
          pcnt_d  = (pw_q == 16'd0) ? 16'd1 : pw_q;
        end
      end
      StOn: begin
        if (!en_q || mode_q || !cmd_q) state_d = StIdle;
      end
      StPulse: begin
        if (!en_q || (pcnt_q <= 16'd1)) state_d = StIdle;
        else                            pcnt_d  = pcnt_q - 16'd1;
      end
      StFault: begin
        if (fclr_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An output edge restarts supervision so the feedback settling lag never counts.
    if (!chk_en || fclr_q || (dout_d != dout_q)) begin
      mm_d = '0;
    end else if (fb_s != dout_q) begin
      if (mm_q != MmMax) mm_d = mm_q + 1'b1;
    end else begin
      mm_d = '0;
    end

    if (chk_en && !fclr_q && (mm_q == MmMax)) state_d = StFault;

    if (fault_d)     led_d = LedFault;
    else if (dout_d) led_d = LedHigh;
    else if (en_q)   led_d = LedEnLow;
    else             led_d = LedOff;

    rd_d = 8'h00;
    if (rd_hit) begin
      case (rd_off)
        OffCtrl:   rd_d = {6'b0, mode_q, en_q};
        OffCmd:    rd_d = {7'b0, cmd_q};
        OffPwLo:   rd_d = pw_q[7:0];
        OffPwHi:   rd_d = pw_q[15:8];
        OffStatus: rd_d = {3'b0, state_q, fault_q, fb_s, dout_q};
        default:   rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      mm_q    <= '0;
      dout_q  <= 1'b0;
      fault_q <= 1'b0;
      led_q   <= LedOff;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      mm_q    <= mm_d;
      dout_q  <= dout_d;
      fault_q <= fault_d;
      led_q   <= led_d;
      rd_q    <= rd_d;
    end
  end

  assign o_dout    = dout_q;
  assign o_fault   = fault_q;
  assign led_ctrl  = led_q;
  assign om_rddata = rd_q;

endmodule

// File: tb/tb_do_ch.sv
// Directed bench for do_ch: two channels on a shared bus with ORed readback.
module tb_do_ch;

  localparam int unsigned FbChk = 8;

  logic        clk, rst_n;
  logic [11:0] paraddr, rdaddr;
  logic        parwren, rdren;
  logic [7:0]  pardata;
  logic [7:0]  rddata0, rddata1, rddata;
  logic        fb0, fb1, dout0, dout1, fault0, fault1;
  logic [1:0]  led0, led1;
  logic        force_en, force_val;

  int checks = 0;
  int errors = 0;

  assign fb0    = force_en ? force_val : dout0;
  assign fb1    = dout1;
  assign rddata = rddata0 | rddata1;

  do_ch #(.CH_ADD(0), .FB_CHK(FbChk)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .im_paraddr(paraddr), .i_parwren(parwren),
    .im_pardata(pardata), .im_rdaddr(rdaddr), .i_rdren(rdren), .om_rddata(rddata0),
    .i_fb(fb0), .o_dout(dout0), .o_fault(fault0), .led_ctrl(led0)
  );

  do_ch #(.CH_ADD(64), .FB_CHK(FbChk)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .im_paraddr(paraddr), .i_parwren(parwren),
    .im_pardata(pardata), .im_rdaddr(rdaddr), .i_rdren(rdren), .om_rddata(rddata1),
    .i_fb(fb1), .o_dout(dout1), .o_fault(fault1), .led_ctrl(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [11:0] a, logic [7:0] d, logic [7:0] e, string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic wr(logic [11:0] a, logic [7:0] d);
    @(negedge clk);
    paraddr = a; pardata = d; parwren = 1'b1;
    @(negedge clk);
    parwren = 1'b0;
  endtask

  task automatic rd(logic [11:0] a, output logic [7:0] d);
    @(negedge clk);
    rdaddr = a; rdren = 1'b1;
    @(negedge clk);
    d = rddata; rdren = 1'b0;
  endtask

  task automatic count_high(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dout0) n++;
    end
  endtask

  logic [7:0] d;
  int         n;
  logic       got;

  initial begin
    rst_n = 1'b0; paraddr = '0; pardata = '0; parwren = 1'b0;
    rdaddr = '0; rdren = 1'b0; force_en = 1'b0; force_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {7'b0, dout0}, 8'h00);
    chk("rst_fault", {7'b0, fault0}, 8'h00);
    chk("rst_led", {6'b0, led0}, 8'h00);
    chk("rst_rddata", rddata, 8'h00);
    rst_n = 1'b1;

    // Register map table: reset readback, PW storage, FCLR not stored, window limits.
    tbl.push_back(mk(1'b0, 12'h000, 8'h00, 8'h00, "rd_ctrl_rst"));
    tbl.push_back(mk(1'b0, 12'h001, 8'h00, 8'h00, "rd_cmd_rst"));
    tbl.push_back(mk(1'b0, 12'h002, 8'h00, 8'h01, "rd_pwlo_rst"));
    tbl.push_back(mk(1'b0, 12'h003, 8'h00, 8'h00, "rd_pwhi_rst"));
    tbl.push_back(mk(1'b0, 12'h004, 8'h00, 8'h00, "rd_status_rst"));
    tbl.push_back(mk(1'b0, 12'h100, 8'h00, 8'h00, "rd_outside"));
    tbl.push_back(mk(1'b0, 12'h005, 8'h00, 8'h00, "rd_unmapped"));
    tbl.push_back(mk(1'b1, 12'h002, 8'hA5, 8'h00, ""));
    tbl.push_back(mk(1'b1, 12'h003, 8'h3C, 8'h00, ""));
    tbl.push_back(mk(1'b0, 12'h002, 8'h00, 8'hA5, "rd_pwlo_wr"));
    tbl.push_back(mk(1'b0, 12'h003, 8'h00, 8'h3C, "rd_pwhi_wr"));
    tbl.push_back(mk(1'b1, 12'h000, 8'h06, 8'h00, ""));
    tbl.push_back(mk(1'b0, 12'h000, 8'h00, 8'h02, "rd_ctrl_fclr_not_stored"));
    tbl.push_back(mk(1'b1, 12'h0C2, 8'h77, 8'h00, ""));
    tbl.push_back(mk(1'b0, 12'h002, 8'h00, 8'hA5, "rd_pwlo_after_outside_wr"));
    tbl.push_back(mk(1'b1, 12'h000, 8'h00, 8'h00, ""));
    tbl.push_back(mk(1'b0, 12'h000, 8'h00, 8'h00, "rd_ctrl_cleared"));
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        rd(tbl[i].addr, d);
        chk(tbl[i].name, d, tbl[i].exp);
      end
    end

    // Level mode with matching feedback.
    wr(12'h000, 8'h01);
    wr(12'h001, 8'h01);
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dout0) begin got = 1'b1; break; end
    end
    chk("lvl_dout_rise", {7'b0, got}, 8'h01);
    chk("lvl_led_high", {6'b0, led0}, 8'h02);
    rd(12'h004, d);
    chk("lvl_status_state", {6'b0, d[4:3]}, 8'h01);
    wr(12'h001, 8'h00);
    repeat (4) @(negedge clk);
    chk("lvl_dout_off", {7'b0, dout0}, 8'h00);
    chk("lvl_led_en", {6'b0, led0}, 8'h01);

    // Pulse mode: width 5 with an ignored retrigger, then width 0 -> 1 cycle.
    wr(12'h000, 8'h03);
    wr(12'h002, 8'h05);
    wr(12'h003, 8'h00);
    wr(12'h001, 8'h01);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) begin paraddr = 12'h001; pardata = 8'h01; parwren = 1'b1; end
      if (i == 2) parwren = 1'b0;
      @(negedge clk);
      if (dout0) n++;
    end
    chk("pulse_width5", 8'(n), 8'd5);
    wr(12'h002, 8'h00);
    wr(12'h001, 8'h01);
    count_high(12, n);
    chk("pulse_width0", 8'(n), 8'd1);

    // Feedback stuck low in level mode -> fault exactly FbChk+2 cycles after rise.
    wr(12'h001, 8'h00);
    wr(12'h000, 8'h01);
    force_en = 1'b1; force_val = 1'b0;
    wr(12'h001, 8'h01);
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (dout0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("flt_dout_rise", {7'b0, got}, 8'h01);
    n = 0;
    for (int k = 0; k < FbChk + 10; k++) begin
      @(negedge clk);
      n++;
      if (fault0) break;
    end
    chk("flt_latency", 8'(n), 8'(FbChk + 2));
    chk("flt_dout_low", {7'b0, dout0}, 8'h00);
    chk("flt_led", {6'b0, led0}, 8'h03);
    rd(12'h004, d);
    chk("flt_status", d, 8'h1C);
    wr(12'h001, 8'h00);
    @(negedge clk);
    chk("flt_sticky", {7'b0, fault0}, 8'h01);
    rd(12'h001, d);
    chk("flt_cmd_stored", d, 8'h00);
    wr(12'h000, 8'h05);
    repeat (3) @(negedge clk);
    chk("fclr_fault", {7'b0, fault0}, 8'h00);
    rd(12'h004, d);
    chk("fclr_status", d, 8'h00);
    rd(12'h000, d);
    chk("fclr_ctrl", d, 8'h01);
    force_en = 1'b0;

    // Mismatch of FbChk-1 cycles is tolerated; FbChk cycles faults.
    wr(12'h001, 8'h01);
    repeat (5) @(negedge clk);
    chk("mm_dout_on", {7'b0, dout0}, 8'h01);
    force_en = 1'b1; force_val = 1'b0;
    repeat (FbChk - 1) @(negedge clk);
    force_en = 1'b0;
    repeat (FbChk + 5) @(negedge clk);
    chk("mm_short_nofault", {7'b0, fault0}, 8'h00);
    chk("mm_short_dout", {7'b0, dout0}, 8'h01);
    force_en = 1'b1;
    repeat (FbChk) @(negedge clk);
    force_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("mm_exact_fault", {7'b0, fault0}, 8'h01);
    wr(12'h001, 8'h00);
    wr(12'h000, 8'h05);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a pulse.
    wr(12'h000, 8'h03);
    wr(12'h002, 8'h14);
    wr(12'h001, 8'h01);
    repeat (4) @(negedge clk);
    chk("rstp_dout_before", {7'b0, dout0}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rstp_dout_async", {7'b0, dout0}, 8'h00);
    chk("rstp_led", {6'b0, led0}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(12'h002, d);
    chk("rstp_pw_reset", d, 8'h01);

    // Two channels sharing the bus.
    wr(12'h000, 8'h01);
    wr(12'h040, 8'h01);
    wr(12'h041, 8'h01);
    repeat (4) @(negedge clk);
    chk("ch1_dout", {7'b0, dout1}, 8'h01);
    chk("ch0_dout_untouched", {7'b0, dout0}, 8'h00);
    rd(12'h004, d);
    chk("ch0_status_only", d, 8'h00);
    rd(12'h044, d);
    chk("ch1_status", d, 8'h0B);
    rd(12'h001, d);
    chk("ch0_cmd", d, 8'h00);
    rd(12'h041, d);
    chk("ch1_cmd", d, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
